// File: rtl/operand_stager_if.sv
// Operand write bus and staged-pair handshake between the stager and its neighbours.
interface operand_stager_if #(
  parameter int unsigned P_WIDTH = 32
) ();
  logic [P_WIDTH-1:0] din;
  logic               din_valid;
  logic               din_slot;
  logic               din_ready;
  logic [1:0]         mode;
  logic [P_WIDTH-1:0] ain;
  logic [P_WIDTH-1:0] bin;
  logic               sel;
  logic               op_valid;
  logic               op_ready;
  logic               err_dup;
  logic [7:0]         pair_count;

  modport master (
    output din, din_valid, din_slot, mode, op_ready,
    input  din_ready, ain, bin, sel, op_valid, err_dup, pair_count
  );

  modport slave (
    input  din, din_valid, din_slot, mode, op_ready,
    output din_ready, ain, bin, sel, op_valid, err_dup, pair_count
  );
endinterface

// File: rtl/operand_stager.sv
// Collects A and B operands from one shared write bus and presents them, with a
// registered swap select, to the downstream switch under a valid/ready handshake.
module operand_stager #(
  parameter int unsigned P_WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  operand_stager_if.slave bus
);

  typedef enum logic [1:0] {StEmpty, StHaveA, StHaveB, StFull} state_e;

  state_e             state_q, state_d;
  logic [P_WIDTH-1:0] a_q, a_d;
  logic [P_WIDTH-1:0] b_q, b_d;
  logic [1:0]         mode_q, mode_d;
  logic               err_q, err_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               wr_en;
  logic               sel_raw;

  assign wr_en = bus.din_valid && (state_q != StFull);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    unique case (state_q)
      StEmpty: begin
        if (wr_en) begin
          if (bus.din_slot) begin
            b_d     = bus.din;
            state_d = StHaveB;
          end else begin
            a_d     = bus.din;
            state_d = StHaveA;
          end
        end
      end
      StHaveA: begin
        if (wr_en) begin
          if (bus.din_slot) begin
            b_d     = bus.din;
            mode_d  = bus.mode;
            state_d = StFull;
          end else begin
            a_d   = bus.din;
            err_d = 1'b1;
          end
        end
      end
      StHaveB: begin
        if (wr_en) begin
          if (!bus.din_slot) begin
            a_d     = bus.din;
            mode_d  = bus.mode;
            state_d = StFull;
          end else begin
            b_d   = bus.din;
            err_d = 1'b1;
          end
        end
      end
      StFull: begin
        if (bus.op_ready) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = StEmpty;
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= 2'b00;
      err_q   <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Select depends on registers only, so it is glitch-free while the pair is held.
  always_comb begin
    sel_raw = 1'b0;
    unique case (mode_q)
      2'b00:   sel_raw = 1'b0;
      2'b01:   sel_raw = 1'b1;
      2'b10:   sel_raw = (a_q > b_q);
      2'b11:   sel_raw = (a_q < b_q);
      default: sel_raw = 1'b0;
    endcase
  end

  assign bus.din_ready  = (state_q != StFull);
  assign bus.op_valid   = (state_q == StFull);
  assign bus.sel        = (state_q == StFull) && sel_raw;
  assign bus.ain        = a_q;
  assign bus.bin        = b_q;
  assign bus.err_dup    = err_q;
  assign bus.pair_count = cnt_q;

endmodule

// File: tb/tb_operand_stager.sv
// Self-checking bench for operand_stager: directed vector table, corner sequences,
// and a randomized run against a slot-based reference model.
module tb_operand_stager;

  logic clk;
  logic rst_n;

  operand_stager_if #(.P_WIDTH(32)) bus ();

  operand_stager #(.P_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit slot, input logic [31:0] d, input logic [1:0] m);
    bus.din_valid = 1'b1;
    bus.din_slot  = slot;
    bus.din       = d;
    bus.mode      = m;
    step();
    bus.din_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Which operand should end up on the switch's aout, then whether that needs a swap.
  function automatic bit ref_sel(input logic [1:0] m, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] want;
    case (m)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    want = (a < b) ? a : b;
      default: want = (a > b) ? a : b;
    endcase
    return want != a;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          b_first;
    logic [1:0]  mode;
    bit          sel;
  } vec_t;

  vec_t vecs[10];

  // Reference model state
  bit          m_has[2];
  logic [31:0] m_val[2];
  logic [1:0]  m_mode;
  bit          m_err;
  int          m_cnt;

  initial begin
    int exp_cnt;
    logic [31:0] hold_a, hold_b;
    logic        hold_sel;

    vecs[0] = '{32'h10, 32'h20, 1'b0, 2'b00, 1'b0};
    vecs[1] = '{32'h9,  32'h5,  1'b1, 2'b10, 1'b1};
    vecs[2] = '{32'h9,  32'h5,  1'b1, 2'b11, 1'b0};
    vecs[3] = '{32'h9,  32'h5,  1'b1, 2'b01, 1'b1};
    vecs[4] = '{32'h7,  32'h7,  1'b0, 2'b10, 1'b0};
    vecs[5] = '{32'h7,  32'h7,  1'b0, 2'b11, 1'b0};
    vecs[6] = '{32'h3,  32'h8,  1'b0, 2'b10, 1'b0};
    vecs[7] = '{32'h3,  32'h8,  1'b1, 2'b11, 1'b1};
    vecs[8] = '{32'hFFFF_FFFF, 32'h0, 1'b0, 2'b10, 1'b1};
    vecs[9] = '{32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 2'b11, 1'b0};

    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.din_slot  = 1'b0;
    bus.mode      = 2'b00;
    bus.op_ready  = 1'b0;
    rst_n         = 1'b0;
    step();
    step();
    chk("rst_din_ready", 32'(bus.din_ready), 32'd1);
    chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
    chk("rst_sel", 32'(bus.sel), 32'd0);
    chk("rst_err_dup", 32'(bus.err_dup), 32'd0);
    chk("rst_pair_count", 32'(bus.pair_count), 32'd0);
    chk("rst_ain", bus.ain, 32'd0);
    chk("rst_bin", bus.bin, 32'd0);
    rst_n = 1'b1;

    // Directed table: mode on the first write is inverted so only the completing write counts.
    exp_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      wr(vecs[i].b_first, vecs[i].b_first ? vecs[i].b : vecs[i].a, ~vecs[i].mode);
      chk("vec_pre_valid", 32'(bus.op_valid), 32'd0);
      wr(!vecs[i].b_first, vecs[i].b_first ? vecs[i].a : vecs[i].b, vecs[i].mode);
      chk("vec_valid", 32'(bus.op_valid), 32'd1);
      chk("vec_ain", bus.ain, vecs[i].a);
      chk("vec_bin", bus.bin, vecs[i].b);
      chk("vec_sel", 32'(bus.sel), 32'(vecs[i].sel));
      chk("vec_err", 32'(bus.err_dup), 32'd0);
      bus.op_ready = 1'b1;
      step();
      bus.op_ready = 1'b0;
      exp_cnt++;
      chk("vec_done_valid", 32'(bus.op_valid), 32'd0);
      chk("vec_done_ready", 32'(bus.din_ready), 32'd1);
      chk("vec_sel_idle", 32'(bus.sel), 32'd0);
      chk("vec_count", 32'(bus.pair_count), 32'(exp_cnt));
    end

    // Hold in FULL while writes keep arriving.
    wr(1'b0, 32'h55, 2'b00);
    wr(1'b1, 32'h44, 2'b10);
    hold_a = 32'h55; hold_b = 32'h44; hold_sel = 1'b1;
    bus.din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.din      = (i % 2 == 0) ? 32'hDEAD_BEEF : 32'h1234_5678;
      bus.din_slot = i[0];
      bus.mode     = 2'b01;
      step();
      chk("hold_din_ready", 32'(bus.din_ready), 32'd0);
      chk("hold_valid", 32'(bus.op_valid), 32'd1);
      chk("hold_ain", bus.ain, hold_a);
      chk("hold_bin", bus.bin, hold_b);
      chk("hold_sel", 32'(bus.sel), 32'(hold_sel));
    end
    bus.din_valid = 1'b0;
    bus.op_ready  = 1'b1;
    step();
    bus.op_ready = 1'b0;
    exp_cnt++;
    chk("hold_release_valid", 32'(bus.op_valid), 32'd0);
    chk("hold_release_ready", 32'(bus.din_ready), 32'd1);
    chk("hold_release_count", 32'(bus.pair_count), 32'(exp_cnt));

    // Duplicate write to slot A.
    wr(1'b0, 32'h1, 2'b00);
    chk("dup_first_err", 32'(bus.err_dup), 32'd0);
    wr(1'b0, 32'h2, 2'b00);
    chk("dup_pulse", 32'(bus.err_dup), 32'd1);
    wr(1'b1, 32'h3, 2'b00);
    chk("dup_pulse_end", 32'(bus.err_dup), 32'd0);
    chk("dup_valid", 32'(bus.op_valid), 32'd1);
    chk("dup_ain", bus.ain, 32'h2);
    chk("dup_bin", bus.bin, 32'h3);
    bus.op_ready = 1'b1;
    step();
    bus.op_ready = 1'b0;

    // Back-to-back duplicates on slot B.
    wr(1'b1, 32'hA, 2'b00);
    wr(1'b1, 32'hB, 2'b00);
    chk("dup2_pulse1", 32'(bus.err_dup), 32'd1);
    wr(1'b1, 32'hC, 2'b00);
    chk("dup2_pulse2", 32'(bus.err_dup), 32'd1);
    step();
    chk("dup2_end", 32'(bus.err_dup), 32'd0);
    chk("dup2_bin", bus.bin, 32'hC);

    // Reset with only a partial pair loaded.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("prst_valid", 32'(bus.op_valid), 32'd0);
    chk("prst_err", 32'(bus.err_dup), 32'd0);
    chk("prst_bin", bus.bin, 32'd0);
    chk("prst_count", 32'(bus.pair_count), 32'd0);
    wr(1'b0, 32'h77, 2'b00);
    step();
    step();
    chk("prst_no_valid", 32'(bus.op_valid), 32'd0);
    wr(1'b1, 32'h66, 2'b11);
    chk("prst_pair_valid", 32'(bus.op_valid), 32'd1);
    chk("prst_pair_sel", 32'(bus.sel), 32'd0);
    bus.op_ready = 1'b1;
    step();
    bus.op_ready = 1'b0;
    chk("prst_pair_count", 32'(bus.pair_count), 32'd1);

    // Reset while a pair is pending drops op_valid right after the edge.
    wr(1'b0, 32'h1, 2'b01);
    wr(1'b1, 32'h2, 2'b01);
    chk("frst_valid_before", 32'(bus.op_valid), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("frst_valid_after", 32'(bus.op_valid), 32'd0);
    chk("frst_err", 32'(bus.err_dup), 32'd0);
    chk("frst_sel", 32'(bus.sel), 32'd0);

    // Randomized run against the reference model.
    do_reset();
    m_has[0] = 1'b0; m_has[1] = 1'b0;
    m_val[0] = '0;   m_val[1] = '0;
    m_mode = 2'b00; m_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      bit full;
      int s;
      bus.din_valid = 1'($urandom_range(0, 1));
      bus.din_slot  = 1'($urandom_range(0, 1));
      bus.din       = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      bus.mode      = 2'($urandom_range(0, 3));
      bus.op_ready  = ($urandom_range(0, 2) != 0);
      s = int'(bus.din_slot);
      m_err = 1'b0;
      if (m_has[0] && m_has[1]) begin
        if (bus.op_ready) begin
          m_has[0] = 1'b0;
          m_has[1] = 1'b0;
          m_cnt++;
        end
      end else if (bus.din_valid) begin
        m_err    = m_has[s];
        m_val[s] = bus.din;
        m_has[s] = 1'b1;
        if (m_has[0] && m_has[1]) m_mode = bus.mode;
      end
      step();
      full = m_has[0] && m_has[1];
      chk("rnd_op_valid", 32'(bus.op_valid), 32'(full));
      chk("rnd_din_ready", 32'(bus.din_ready), 32'(!full));
      chk("rnd_err_dup", 32'(bus.err_dup), 32'(m_err));
      chk("rnd_ain", bus.ain, m_val[0]);
      chk("rnd_bin", bus.bin, m_val[1]);
      chk("rnd_sel", 32'(bus.sel), 32'(full ? ref_sel(m_mode, m_val[0], m_val[1]) : 1'b0));
      chk("rnd_count", 32'(bus.pair_count), 32'(m_cnt % 256));
    end

    // 256 pairs at full rate: count wraps to zero, one pair per 3 cycles.
    bus.din_valid = 1'b0;
    bus.op_ready  = 1'b0;
    do_reset();
    bus.din_valid = 1'b1;
    bus.op_ready  = 1'b1;
    bus.mode      = 2'b00;
    for (int i = 0; i < 256; i++) begin
      bus.din_slot = 1'b0;
      bus.din      = 32'(i);
      step();
      chk("wrap_phase1_valid", 32'(bus.op_valid), 32'd0);
      bus.din_slot = 1'b1;
      bus.din      = 32'(i + 1000);
      step();
      chk("wrap_phase2_valid", 32'(bus.op_valid), 32'd1);
      chk("wrap_count_pending", 32'(bus.pair_count), 32'(i % 256));
      bus.din_slot = 1'b0;
      step();
      chk("wrap_phase3_ready", 32'(bus.din_ready), 32'd1);
    end
    bus.din_valid = 1'b0;
    bus.op_ready  = 1'b0;
    chk("wrap_count_zero", 32'(bus.pair_count), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
